sockit_spi_ser: RTL and testbench

- SPI serializer/deserializer, directly downstream of the CPU register block.
- Consumes command-output transfers (control + 32-bit data), drives SPI pads (sclk, slave selects, sio[3:0]) in 3-wire/SPI/dual/quad mode, and samples input lanes.
- Returns received words to the register block over the command-input handshake.
- One command = one burst of 1..32 SPI clock cycles; sclk = clk/2.

---
 rtl/sockit_spi_pkg.sv | 32 +++
 rtl/sockit_spi_shf.sv | 49 ++++
 rtl/sockit_spi_ser.sv | 107 ++++++++++
 tb/tb_sockit_spi_ser.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/sockit_spi_pkg.sv
// sockit_spi_pkg: shared types for the SPI serializer (lane modes, command/response fields, FSM states)
package sockit_spi_pkg;

    typedef enum logic [1:0] {IOM_3W, IOM_SPI, IOM_DUAL, IOM_QUAD} iom_t;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_RSP} state_t;

    typedef struct packed {
        logic [4:0] cnt;
        logic       ien;
        logic       oen;
        iom_t       iom;
        logic       sso;
        logic       cke;
        logic       rsv;
    } cmo_ctl_t;

    typedef struct packed {
        logic rsv;
        logic trunc;
        iom_t iom;
    } cmi_ctl_t;

    function automatic logic [1:0] lane_lg(input iom_t m);
        return m == IOM_QUAD ? 2'd2 : m == IOM_DUAL ? 2'd1 : 2'd0;
    endfunction

    function automatic logic [3:0] lane_mask(input iom_t m);
        return m == IOM_QUAD ? 4'hF : m == IOM_DUAL ? 4'h3 : 4'h1;
    endfunction

endpackage

// File: rtl/sockit_spi_shf.sv
// sockit_spi_shf: 32-bit tx/rx shifter with lane mux, 3-wire loopback and final right-justify
module sockit_spi_shf
    import sockit_spi_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ld,
    input  logic        smp,
    input  logic        shf,
    input  logic        dir,
    input  iom_t        iom,
    input  logic        oen,
    input  logic [5:0]  nl,
    input  logic [31:0] dat,
    input  logic [3:0]  sio_i,
    output logic [3:0]  sio_o,
    output logic [31:0] rdat
);
    logic [31:0] tx, rx;
    logic [3:0]  tg, rg;
    logic [2:0]  ln;
    assign ln = 3'd1 << lane_lg(iom);
    always_comb begin
        tg = dir ? (iom == IOM_QUAD ? tx[31:28] : iom == IOM_DUAL ? {2'b0, tx[31:30]} : {3'b0, tx[31]})
                 : (iom == IOM_QUAD ? tx[3:0]   : iom == IOM_DUAL ? {2'b0, tx[1:0]}   : {3'b0, tx[0]});
        // 3-wire with output enabled shares one pin, so the receiver sees its own drive
        rg = iom == IOM_QUAD ? sio_i
           : iom == IOM_DUAL ? {2'b0, sio_i[1:0]}
           : iom == IOM_SPI  ? {3'b0, sio_i[1]}
           : {3'b0, oen ? tg[0] : sio_i[0]};
    end
    assign sio_o = tg;
    // LSB-first data accumulates at the top and is brought down to bit 0 here
    assign rdat = dir ? rx : rx >> (6'd32 - nl);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx <= '0;
            rx <= '0;
        end else if (ld) begin
            tx <= dat;
            rx <= '0;
        end else begin
            if (shf)
                tx <= dir ? tx << ln : tx >> ln;
            if (smp)
                rx <= dir ? (rx << ln) | {28'b0, rg} : (rx >> ln) | ({rg, 28'b0} << (3'd4 - ln));
        end
    end
endmodule

// File: rtl/sockit_spi_ser.sv
// sockit_spi_ser: SPI serializer/deserializer between the command handshakes and the SPI pads
module sockit_spi_ser
    import sockit_spi_pkg::*;
#(
    parameter int SSW = 8,
    parameter int CCO = 12,
    parameter int CCI = 4,
    parameter int CDW = 32
)(
    input  logic           clk,
    input  logic           rst,
    input  logic           cfg_pol,
    input  logic           cfg_pha,
    input  logic           cfg_dir,
    input  logic           cfg_coe,
    input  logic           cfg_soe,
    input  logic [SSW-1:0] cfg_sss,
    input  logic           cmo_req,
    input  logic [CCO-1:0] cmo_ctl,
    input  logic [CDW-1:0] cmo_dat,
    output logic           cmo_grt,
    output logic           cmi_req,
    output logic [CCI-1:0] cmi_ctl,
    output logic [CDW-1:0] cmi_dat,
    input  logic           cmi_grt,
    output logic           spi_sclk_o,
    output logic           spi_sclk_e,
    output logic [SSW-1:0] spi_ss_n_o,
    output logic           spi_ss_e,
    output logic [3:0]     spi_sio_o,
    output logic [3:0]     spi_sio_e,
    input  logic [3:0]     spi_sio_i
);
    state_t     state;
    cmo_ctl_t   ctl, c;
    cmi_ctl_t   rc;
    logic [5:0] n, nn, cnt1, mx, bcnt;
    logic       trc, tr, h, ss_act, acc, run, fin, unused_rsv;
    logic [3:0] shf_o;
    logic [31:0] rdat;
    assign c    = cmo_ctl_t'(cmo_ctl);
    assign cnt1 = {1'b0, c.cnt} + 6'd1;
    assign mx   = 6'd32 >> lane_lg(c.iom);
    assign tr   = cnt1 > mx;
    assign nn   = tr ? mx : cnt1;
    // grant comes from registered state only; upstream request depends on it
    assign cmo_grt = state == ST_IDLE;
    assign acc     = cmo_req & cmo_grt;
    assign run     = state == ST_RUN;
    assign fin     = run && h && bcnt == n - 6'd1;
    assign cmi_req = state == ST_RSP;
    assign rc      = '{rsv: 1'b0, trunc: trc, iom: ctl.iom};
    assign cmi_ctl = rc;
    assign unused_rsv = ctl.rsv;
    assign spi_sclk_o = (run && ctl.cke) ? cfg_pol ^ (cfg_pha ? ~h : h) : cfg_pol;
    assign spi_sclk_e = cfg_coe;
    assign spi_ss_e   = cfg_soe;
    assign spi_ss_n_o = ~(cfg_sss & {SSW{ss_act}});
    assign spi_sio_o  = run ? shf_o : 4'b0;
    assign spi_sio_e  = (run && ctl.oen) ? lane_mask(ctl.iom) : 4'b0;
    sockit_spi_shf u_shf (
        .clk   (clk),
        .rst   (rst),
        .ld    (acc),
        .smp   (run & ~h),
        .shf   (run & h),
        .dir   (cfg_dir),
        .iom   (ctl.iom),
        .oen   (ctl.oen),
        .nl    (n << lane_lg(ctl.iom)),
        .dat   (cmo_dat),
        .sio_i (spi_sio_i),
        .sio_o (shf_o),
        .rdat  (rdat)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            ctl     <= '0;
            n       <= '0;
            trc     <= 1'b0;
            h       <= 1'b0;
            bcnt    <= '0;
            ss_act  <= 1'b0;
            cmi_dat <= '0;
        end else if (acc) begin
            state  <= ST_RUN;
            ctl    <= c;
            n      <= nn;
            trc    <= tr;
            h      <= 1'b0;
            bcnt   <= '0;
            ss_act <= c.sso;
        end else if (run) begin
            h <= ~h;
            if (h)
                bcnt <= bcnt + 6'd1;
            if (fin) begin
                state <= ctl.ien ? ST_RSP : ST_IDLE;
                if (ctl.ien)
                    cmi_dat <= rdat;
            end
        end else if (cmi_req && cmi_grt) begin
            state <= ST_IDLE;
        end
    end
endmodule

// File: tb/tb_sockit_spi_ser.sv
// tb_sockit_spi_ser: directed scenarios for the SPI serializer with hand-computed expectations
module tb_sockit_spi_ser;
    logic        clk = 0, rst = 1;
    logic        cfg_pol = 0, cfg_pha = 0, cfg_dir = 1, cfg_coe = 1, cfg_soe = 1;
    logic [7:0]  cfg_sss = 8'h01;
    logic        cmo_req = 0, cmi_grt = 0, lb = 0;
    logic [11:0] cmo_ctl = 0;
    logic [31:0] cmo_dat = 0;
    logic        cmo_grt, cmi_req, spi_sclk_o, spi_sclk_e, spi_ss_e;
    logic [3:0]  cmi_ctl, spi_sio_o, spi_sio_e, spi_sio_i, sio_drv = 0;
    logic [31:0] cmi_dat;
    logic [7:0]  spi_ss_n_o;
    int          cmp = 0, err = 0;

    // loopback wires the data-out pin onto the SPI MISO lane
    assign spi_sio_i = lb ? {2'b0, spi_sio_o[0], 1'b0} : sio_drv;
    always #5 clk = ~clk;

    sockit_spi_ser dut (
        .clk(clk), .rst(rst), .cfg_pol(cfg_pol), .cfg_pha(cfg_pha), .cfg_dir(cfg_dir),
        .cfg_coe(cfg_coe), .cfg_soe(cfg_soe), .cfg_sss(cfg_sss),
        .cmo_req(cmo_req), .cmo_ctl(cmo_ctl), .cmo_dat(cmo_dat), .cmo_grt(cmo_grt),
        .cmi_req(cmi_req), .cmi_ctl(cmi_ctl), .cmi_dat(cmi_dat), .cmi_grt(cmi_grt),
        .spi_sclk_o(spi_sclk_o), .spi_sclk_e(spi_sclk_e), .spi_ss_n_o(spi_ss_n_o),
        .spi_ss_e(spi_ss_e), .spi_sio_o(spi_sio_o), .spi_sio_e(spi_sio_e), .spi_sio_i(spi_sio_i)
    );

    function automatic logic [11:0] mk(input logic [4:0] cnt, input logic ien, input logic oen,
                                       input logic [1:0] iom, input logic sso, input logic cke);
        return {cnt, ien, oen, iom, sso, cke, 1'b0};
    endfunction

    task issue(input logic [11:0] ctl, input logic [31:0] dat);
        @(negedge clk);
        cmo_ctl = ctl;
        cmo_dat = dat;
        cmo_req = 1;
        @(posedge clk);
        #1 cmo_req = 0;
    endtask

    task wait_idle;
        for (int i = 0; i < 200 && cmo_grt !== 1'b1; i++) @(negedge clk);
        cmp++; if (cmo_grt !== 1'b1) begin err++; $display("FAIL wait_idle: cmo_grt=%b want 1 (timeout)", cmo_grt); end
    endtask

    task test_reset;
        cfg_pol = 1;
        #12;
        cmp++; if (spi_sclk_o !== 1'b1) begin err++; $display("FAIL rst_sclk_pol1: got %b want 1", spi_sclk_o); end
        cfg_pol = 0;
        #1;
        cmp++; if (spi_sclk_o !== 1'b0) begin err++; $display("FAIL rst_sclk_pol0: got %b want 0", spi_sclk_o); end
        cmp++; if ({cmi_req, cmi_ctl, cmi_dat} !== 37'h0) begin err++; $display("FAIL rst_cmi: req=%b ctl=%h dat=%h want 0", cmi_req, cmi_ctl, cmi_dat); end
        cmp++; if ({spi_sio_e, spi_sio_o} !== 8'h00) begin err++; $display("FAIL rst_sio: e=%h o=%h want 0", spi_sio_e, spi_sio_o); end
        cmp++; if (spi_ss_n_o !== 8'hFF) begin err++; $display("FAIL rst_ss_n: got %h want ff", spi_ss_n_o); end
        cmp++; if (cmo_grt !== 1'b1) begin err++; $display("FAIL rst_grt: got %b want 1", cmo_grt); end
        @(negedge clk) rst = 0;
    endtask

    task test_spi_loopback;
        logic [7:0] seq;
        int rises, bad;
        logic prev;
        seq = 0; rises = 0; bad = 0; prev = 0;
        cfg_pol = 0; cfg_pha = 0; cfg_dir = 1; lb = 1;
        issue(mk(5'd7, 1, 1, 2'd1, 1, 1), 32'hA500_0000);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k % 2 == 0) seq = {seq[6:0], spi_sio_o[0]};
            if (spi_sclk_o && !prev) rises++;
            prev = spi_sclk_o;
            if (cmo_grt !== 1'b0 || cmi_req !== 1'b0 || spi_sio_e !== 4'b0001) bad++;
        end
        @(negedge clk);
        if (spi_sclk_o && !prev) rises++;
        lb = 0;
        cmp++; if (seq !== 8'hA5) begin err++; $display("FAIL spi_out_seq: got %h want a5", seq); end
        cmp++; if (rises !== 8) begin err++; $display("FAIL spi_sclk_rises: got %0d want 8", rises); end
        cmp++; if (bad !== 0) begin err++; $display("FAIL spi_run_window: got %0d bad cycles want 0", bad); end
        cmp++; if (cmi_req !== 1'b1) begin err++; $display("FAIL spi_rsp_req: got %b want 1", cmi_req); end
        cmp++; if (cmi_dat !== 32'h0000_00A5) begin err++; $display("FAIL spi_rsp_dat: got %h want 000000a5", cmi_dat); end
        cmp++; if (cmi_ctl !== 4'b0001) begin err++; $display("FAIL spi_rsp_ctl: got %b want 0001", cmi_ctl); end
        cmi_grt = 1;
        @(posedge clk);
        #1 cmi_grt = 0;
        cmp++; if ({cmi_req, cmo_grt} !== 2'b01) begin err++; $display("FAIL spi_grant: req/grt=%b want 01", {cmi_req, cmo_grt}); end
    endtask

    task test_quad_trunc;
        logic [31:0] word;
        int bad;
        word = 0; bad = 0;
        cfg_dir = 1; sio_drv = 4'hC;
        issue(mk(5'd31, 1, 1, 2'd3, 1, 1), 32'h1234_5678);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k % 2 == 0) word = {word[27:0], spi_sio_o};
            if (spi_sio_e !== 4'hF || cmi_req !== 1'b0) bad++;
        end
        @(negedge clk);
        cmp++; if (word !== 32'h1234_5678) begin err++; $display("FAIL quad_nibbles: got %h want 12345678", word); end
        cmp++; if (bad !== 0) begin err++; $display("FAIL quad_run_window: got %0d bad cycles want 0", bad); end
        cmp++; if (cmi_req !== 1'b1) begin err++; $display("FAIL quad_rsp_req: got %b want 1", cmi_req); end
        cmp++; if (cmi_ctl !== 4'b0111) begin err++; $display("FAIL quad_trunc_ctl: got %b want 0111", cmi_ctl); end
        cmp++; if (cmi_dat !== 32'hCCCC_CCCC) begin err++; $display("FAIL quad_rsp_dat: got %h want cccccccc", cmi_dat); end
        cmi_grt = 1;
        @(posedge clk);
        #1 cmi_grt = 0;
        sio_drv = 0;
    endtask

    task test_dual_lsb;
        int rises, bad;
        logic prev;
        rises = 0; bad = 0; prev = 0;
        cfg_dir = 0; sio_drv = 4'b0010;
        issue(mk(5'd3, 1, 0, 2'd2, 1, 1), 32'hFFFF_FFFF);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (spi_sclk_o && !prev) rises++;
            prev = spi_sclk_o;
            if (spi_sio_e !== 4'h0) bad++;
        end
        @(negedge clk);
        cmp++; if (rises !== 4) begin err++; $display("FAIL dual_sclk_rises: got %0d want 4", rises); end
        cmp++; if (bad !== 0) begin err++; $display("FAIL dual_sio_e: got %0d enabled cycles want 0", bad); end
        cmp++; if (cmi_dat !== 32'h0000_00AA) begin err++; $display("FAIL dual_rsp_dat: got %h want 000000aa", cmi_dat); end
        cmp++; if (cmi_ctl !== 4'b0010) begin err++; $display("FAIL dual_rsp_ctl: got %b want 0010", cmi_ctl); end
        cmi_grt = 1;
        @(posedge clk);
        #1 cmi_grt = 0;
        cfg_dir = 1; sio_drv = 0;
    endtask

    task test_ss_chain;
        cfg_sss = 8'h05;
        issue(mk(5'd1, 0, 1, 2'd1, 1, 1), 32'h0);
        @(negedge clk);
        cmp++; if (spi_ss_n_o !== 8'hFA) begin err++; $display("FAIL ss_first_run: got %h want fa", spi_ss_n_o); end
        wait_idle;
        cmp++; if (spi_ss_n_o !== 8'hFA) begin err++; $display("FAIL ss_held_idle: got %h want fa", spi_ss_n_o); end
        cmp++; if (cmi_req !== 1'b0) begin err++; $display("FAIL ss_no_rsp: got %b want 0", cmi_req); end
        cmp++; if ({spi_ss_e, spi_sclk_e} !== 2'b11) begin err++; $display("FAIL ss_oe: got %b want 11", {spi_ss_e, spi_sclk_e}); end
        issue(mk(5'd1, 0, 1, 2'd1, 0, 1), 32'h0);
        @(negedge clk);
        cmp++; if (spi_ss_n_o !== 8'hFF) begin err++; $display("FAIL ss_deselect: got %h want ff", spi_ss_n_o); end
        wait_idle;
    endtask

    task test_back_to_back_stall;
        int bad;
        bad = 0;
        cfg_dir = 1; sio_drv = 4'b0010;
        issue(mk(5'd0, 1, 0, 2'd1, 1, 1), 32'h0);
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (cmi_req !== 1'b1 || cmi_dat !== 32'h1 || cmi_ctl !== 4'b0001 || cmo_grt !== 1'b0) bad++;
            cmo_ctl = mk(5'd0, 0, 1, 2'd3, 1, 1);
            cmo_req = 1;
        end
        cmp++; if (bad !== 0) begin err++; $display("FAIL stall_hold: got %0d bad cycles want 0", bad); end
        cmi_grt = 1;
        @(posedge clk);
        #1 cmi_grt = 0;
        cmp++; if ({cmi_req, cmo_grt} !== 2'b01) begin err++; $display("FAIL stall_release: req/grt=%b want 01", {cmi_req, cmo_grt}); end
        @(posedge clk);
        #1 cmo_req = 0;
        cmp++; if ({cmo_grt, spi_sio_e} !== 5'h0F) begin err++; $display("FAIL stall_next_accept: grt/sio_e=%h want 0f", {cmo_grt, spi_sio_e}); end
        wait_idle;
        sio_drv = 0;
    endtask

    task test_rst_mid_run;
        int bad;
        bad = 0;
        cfg_pol = 1; cfg_sss = 8'hFF;
        issue(mk(5'd7, 1, 1, 2'd3, 1, 0), 32'hFFFF_FFFF);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (spi_sclk_o !== 1'b1) bad++;
        end
        cmp++; if (bad !== 0) begin err++; $display("FAIL cke0_sclk_idle: got %0d toggled cycles want 0", bad); end
        cmp++; if ({spi_ss_n_o, spi_sio_e} !== 12'h00F) begin err++; $display("FAIL pre_rst_run: ss_n/sio_e=%h want 00f", {spi_ss_n_o, spi_sio_e}); end
        #2 rst = 1;
        #1;
        cmp++; if ({spi_sclk_o, spi_ss_n_o, spi_sio_e, spi_sio_o} !== 17'h1FF00) begin err++; $display("FAIL rst_mid_run_pads: got %h want 1ff00", {spi_sclk_o, spi_ss_n_o, spi_sio_e, spi_sio_o}); end
        cmp++; if ({cmo_grt, cmi_req} !== 2'b10) begin err++; $display("FAIL rst_mid_run_hs: grt/req=%b want 10", {cmo_grt, cmi_req}); end
        @(negedge clk) rst = 0;
        cfg_pol = 0;
        repeat (20) @(negedge clk);
        cmp++; if ({cmi_req, cmo_grt} !== 2'b01) begin err++; $display("FAIL rst_rsp_discard: req/grt=%b want 01", {cmi_req, cmo_grt}); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_spi_loopback;
        test_quad_trunc;
        test_dual_lsb;
        test_ss_chain;
        test_back_to_back_stall;
        test_rst_mid_run;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end
endmodule
